// File: rtl/alu_result_arbiter.sv
// Result collector for NCH operation units: fixed-priority or round-robin grant into a
// DEPTH-entry FIFO, with each entry tagged by its source channel, plus a contention counter.
module alu_result_arbiter #(
  parameter int unsigned W     = 8,
  parameter int unsigned NCH   = 5,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned SW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH*W-1:0] res_data,
  input  logic [NCH-1:0]   res_valid,
  output logic [NCH-1:0]   res_ready,
  input  logic             rr_mode,
  output logic [W-1:0]     y,
  output logic [SW-1:0]    y_src,
  output logic             y_valid,
  input  logic             y_ready,
  input  logic             cnt_clr,
  output logic [7:0]       coll_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]    count_q, count_d;
  logic [AW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [W-1:0]   mem_data_q [DEPTH];
  logic [SW-1:0]  mem_src_q  [DEPTH];
  logic [SW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]     coll_cnt_q, coll_cnt_d;

  logic           grant_vld;
  logic [SW-1:0]  grant_idx;
  logic           push, pop;
  logic [W-1:0]   push_data;

  always_comb begin : grant_search
    logic [SW:0] idx_sum;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx_sum   = '0;
    if (rr_mode) begin
      // Walk downward so the candidate nearest rr_ptr_q is the last one written.
      for (int k = NCH - 1; k >= 0; k--) begin
        idx_sum = {1'b0, rr_ptr_q} + (SW+1)'(k);
        if (idx_sum >= (SW+1)'(NCH)) idx_sum = idx_sum - (SW+1)'(NCH);
        if (res_valid[idx_sum[SW-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = idx_sum[SW-1:0];
        end
      end
    end else begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (res_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SW'(i);
        end
      end
    end
    // A full FIFO blocks the grant even when a pop frees a slot this cycle.
    if (rst || count_q == (AW+1)'(DEPTH)) grant_vld = 1'b0;
  end

  always_comb begin
    res_ready = '0;
    if (grant_vld) res_ready = NCH'(1) << grant_idx;
  end

  assign push      = grant_vld;
  assign push_data = res_data[grant_idx*W +: W];
  assign y_valid   = (count_q != '0);
  assign pop       = y_valid && y_ready;
  assign y         = y_valid ? mem_data_q[rd_ptr_q] : '0;
  assign y_src     = y_valid ? mem_src_q[rd_ptr_q] : '0;
  assign coll_cnt  = coll_cnt_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (push && rr_mode) begin
      rr_ptr_d = (grant_idx == SW'(NCH - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_comb begin
    coll_cnt_d = coll_cnt_q;
    if (cnt_clr) begin
      coll_cnt_d = '0;
    end else if (($countones(res_valid) > 1) && (coll_cnt_q != 8'hFF)) begin
      coll_cnt_d = coll_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rr_ptr_q   <= '0;
      coll_cnt_q <= '0;
    end else begin
      count_q    <= count_d;
      rr_ptr_q   <= rr_ptr_d;
      coll_cnt_q <= coll_cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage carries no reset; occupancy is tracked solely by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= push_data;
      mem_src_q[wr_ptr_q]  <= grant_idx;
    end
  end

endmodule
